// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered-output ALU for the SESO datapath.
//
// One operation is accepted per in_valid && in_ready. Single-cycle ops and the
// immediate load complete on the accept edge. out_valid pulses for one cycle
// with the registered result and flags. Outputs hold between pulses, and there
// is no output backpressure.
//
// Optional feature macro: ALU_SEQ_MUL_EN. When defined, opcode 12 runs a
// WIDTH-cycle shift-add multiplier, and in_ready is low while the multiply is
// in progress. When undefined, opcode 12 behaves like the undefined opcodes
// and in_ready is tied high.
//
// Ports:
//   CLK        clock, rising edge
//   reset      synchronous, active-high reset
//   in_valid   operation request
//   in_ready   block can accept an operation
//   op         4-bit opcode
//   imm_sel    1: result = imm, op ignored
//   imm        immediate operand
//   acc        accumulator operand, also the shift amount
//   rb         register operand
//   out_valid  one-cycle completion pulse
//   result     registered result
//   flag_z     registered zero flag
//   flag_n     registered negative flag
//   flag_c     registered carry/borrow flag
//   to_jump    registered branch condition, set by CMP-equal
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             imm_sel,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] rb,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             to_jump
);

    localparam logic [3:0] OpLsl  = 4'd0;
    localparam logic [3:0] OpLsr  = 4'd1;
    localparam logic [3:0] OpAdd  = 4'd2;
    localparam logic [3:0] OpAnd  = 4'd3;
    localparam logic [3:0] OpOrr  = 4'd4;
    localparam logic [3:0] OpEor  = 4'd5;
    localparam logic [3:0] OpTake = 4'd6;
    localparam logic [3:0] OpMove = 4'd7;
    localparam logic [3:0] OpLdr  = 4'd8;
    localparam logic [3:0] OpStr  = 4'd9;
    localparam logic [3:0] OpCmp  = 4'd10;
    localparam logic [3:0] OpSub  = 4'd11;

    // WIDTH always fits in WIDTH bits for WIDTH >= 2.
    localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_jump;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH:0]   lsl_w;
    logic [WIDTH:0]   lsr_w;
    logic             eq;

    logic             fin_valid;
    logic [WIDTH-1:0] fin_res;
    logic             fin_c;
    logic             fin_jump;

    // Extra top bit catches carry/borrow. Shifts use a guard bit on the
    // outgoing side, so it holds the last bit shifted out (0 for a shift by 0).
    assign sum_w  = {1'b0, acc} + {1'b0, rb};
    assign diff_w = {1'b0, acc} - {1'b0, rb};
    assign lsl_w  = {1'b0, rb} << acc;
    assign lsr_w  = {rb, 1'b0} >> acc;
    assign eq     = (acc == rb);

    always_comb begin
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_jump = 1'b0;
        if (imm_sel) begin
            alu_res = imm;
        end else begin
            case (op)
                OpLsl: begin
                    if (acc < WidthVal) begin
                        alu_res = lsl_w[WIDTH-1:0];
                        alu_c   = lsl_w[WIDTH];
                    end
                end
                OpLsr: begin
                    if (acc < WidthVal) begin
                        alu_res = lsr_w[WIDTH:1];
                        alu_c   = lsr_w[0];
                    end
                end
                OpAdd: begin
                    alu_res = sum_w[WIDTH-1:0];
                    alu_c   = sum_w[WIDTH];
                end
                OpAnd:  alu_res = acc & rb;
                OpOrr:  alu_res = acc | rb;
                OpEor:  alu_res = acc ^ rb;
                OpTake: alu_res = rb;
                OpMove: alu_res = acc;
                OpLdr:  alu_res = rb;
                OpStr:  alu_res = rb;
                OpCmp: begin
                    alu_res  = {{(WIDTH-1){1'b0}}, eq};
                    alu_c    = diff_w[WIDTH];
                    alu_jump = eq;
                end
                OpSub: begin
                    alu_res = diff_w[WIDTH-1:0];
                    alu_c   = diff_w[WIDTH];
                end
                default: alu_res = '0;
            endcase
        end
    end

`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0]  OpMul = 4'd12;
    localparam int unsigned CntW  = $clog2(WIDTH);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e             state;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   mplier;
    logic [CntW-1:0]    cnt;
    logic               start_mul;
    logic               last_iter;

    assign in_ready  = (state == StIdle);
    assign start_mul = in_valid && in_ready && !imm_sel && (op == OpMul);
    assign prod_step = mplier[0] ? (prod + mcand) : prod;
    assign last_iter = (state == StBusy) && (cnt == CntW'(WIDTH - 1));
`else
    assign in_ready = 1'b1;
`endif

    // Selects what, if anything, completes on this edge.
    always_comb begin
        fin_valid = in_valid && in_ready;
        fin_res   = alu_res;
        fin_c     = alu_c;
        fin_jump  = alu_jump;
`ifdef ALU_SEQ_MUL_EN
        if (start_mul) begin
            fin_valid = 1'b0;
        end
        if (last_iter) begin
            fin_valid = 1'b1;
            fin_res   = prod_step[WIDTH-1:0];
            fin_c     = |prod_step[2*WIDTH-1:WIDTH];
            fin_jump  = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            to_jump   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            state     <= StIdle;
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
`endif
        end else begin
            out_valid <= fin_valid;
            if (fin_valid) begin
                result  <= fin_res;
                flag_z  <= (fin_res == '0);
                flag_n  <= fin_res[WIDTH-1];
                flag_c  <= fin_c;
                to_jump <= fin_jump;
            end
`ifdef ALU_SEQ_MUL_EN
            if (start_mul) begin
                state  <= StBusy;
                prod   <= '0;
                mcand  <= {{WIDTH{1'b0}}, acc};
                mplier <= rb;
                cnt    <= '0;
            end else if (state == StBusy) begin
                prod   <= prod_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (last_iter) begin
                    state <= StIdle;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH = 8). The multiplier checks are built
// only when ALU_SEQ_MUL_EN is defined; otherwise opcode 12 is checked as
// undefined.
module tb_alu_seq;

    logic       CLK;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic       imm_sel;
    logic [7:0] imm;
    logic [7:0] acc;
    logic [7:0] rb;
    logic       out_valid;
    logic [7:0] result;
    logic       flag_z;
    logic       flag_n;
    logic       flag_c;
    logic       to_jump;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .imm_sel   (imm_sel),
        .imm       (imm),
        .acc       (acc),
        .rb        (rb),
        .out_valid (out_valid),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .to_jump   (to_jump)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
        logic       n;
        logic       c;
        logic       j;
    } vec_t;

    // op, acc, rb, result, Z, N, C, to_jump
    vec_t vecs [18] = '{
        '{4'd2,  8'hF0, 8'h20, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0},
        '{4'd11, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0},
        '{4'd0,  8'h01, 8'h81, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0},
        '{4'd1,  8'h08, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0},
        '{4'd1,  8'h01, 8'h81, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0},
        '{4'd0,  8'h00, 8'h81, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0},
        '{4'd1,  8'h07, 8'h81, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0},
        '{4'd4,  8'h0C, 8'h30, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0},
        '{4'd5,  8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0},
        '{4'd6,  8'h11, 8'h22, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0},
        '{4'd7,  8'h11, 8'h22, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0},
        '{4'd8,  8'h11, 8'hA2, 8'hA2, 1'b0, 1'b1, 1'b0, 1'b0},
        '{4'd9,  8'h11, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0},
        '{4'd10, 8'h05, 8'h07, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0},
        '{4'd10, 8'h07, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0},
        '{4'd2,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0},
        '{4'd13, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0},
        '{4'd15, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; accepts on the next edge and returns at posedge+1.
    task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        op       = o;
        acc      = a;
        rb       = b;
        imm_sel  = 1'b0;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] res, input logic z,
                             input logic n, input logic c, input logic j);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".result"},    32'(result),    32'(res));
        check({tag, ".z"},         32'(flag_z),    32'(z));
        check({tag, ".n"},         32'(flag_n),    32'(n));
        check({tag, ".c"},         32'(flag_c),    32'(c));
        check({tag, ".jump"},      32'(to_jump),   32'(j));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int busy;
        reset    = 1'b1;
        in_valid = 1'b0;
        op       = 4'd0;
        imm_sel  = 1'b0;
        imm      = 8'h00;
        acc      = 8'h00;
        rb       = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.result",    32'(result),    32'd0);
        check("rst.z",         32'(flag_z),    32'd0);
        check("rst.n",         32'(flag_n),    32'd0);
        check("rst.c",         32'(flag_c),    32'd0);
        check("rst.jump",      32'(to_jump),   32'd0);
        reset = 1'b0;

        // Back-to-back accepts through the whole table.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b);
            check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].n,
                      vecs[i].c, vecs[i].j);
        end

        // Result held, pulse gone on an idle cycle.
        run_op(4'd11, 8'h05, 8'h07);
        idle_cycle();
        check("hold.out_valid", 32'(out_valid), 32'd0);
        check("hold.result",    32'(result),    32'hFE);

        // CMP-equal sets to_jump, held through idle, cleared by AND.
        run_op(4'd10, 8'h3C, 8'h3C);
        check_out("cmp_eq", 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycle();
        idle_cycle();
        check("cmp_hold.jump",      32'(to_jump),   32'd1);
        check("cmp_hold.out_valid", 32'(out_valid), 32'd0);
        run_op(4'd3, 8'h0F, 8'hF0);
        check_out("and_z", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Immediate overrides an ADD that would otherwise carry.
        op       = 4'd2;
        acc      = 8'hFF;
        rb       = 8'hFF;
        imm      = 8'h80;
        imm_sel  = 1'b1;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        imm_sel  = 1'b0;
        check_out("imm", 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef ALU_SEQ_MUL_EN
        // MUL 0x12 * 0x11 = 0x132; a held request waits for in_ready.
        run_op(4'd12, 8'h12, 8'h11);
        op       = 4'd2;
        acc      = 8'h01;
        rb       = 8'h02;
        in_valid = 1'b1;
        busy     = 0;
        pulses   = 0;
        while (!in_ready && busy < 20) begin
            if (out_valid) pulses++;
            busy++;
            @(posedge CLK);
            #1;
        end
        check("mul.busy_cycles", 32'(busy),   32'd8);
        check("mul.early_pulse", 32'(pulses), 32'd0);
        check("mul.in_ready",    32'(in_ready), 32'd1);
        check_out("mul", 8'h32, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        check_out("after_mul", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        run_op(4'd12, 8'h12, 8'h11);
        check_out("op12_undef", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("op12.in_ready", 32'(in_ready), 32'd1);
`endif

        // Reset clears non-zero state (and discards an in-flight MUL).
        run_op(4'd2, 8'hFF, 8'h02);
        check_out("pre_rst", 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef ALU_SEQ_MUL_EN
        run_op(4'd12, 8'h12, 8'h11);
        idle_cycle();
        idle_cycle();
`endif
        reset = 1'b1;
        @(posedge CLK);
        #1;
        reset = 1'b0;
        check("rst2.in_ready",  32'(in_ready),  32'd1);
        check("rst2.out_valid", 32'(out_valid), 32'd0);
        check("rst2.result",    32'(result),    32'd0);
        check("rst2.c",         32'(flag_c),    32'd0);
        check("rst2.z",         32'(flag_z),    32'd0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            idle_cycle();
            if (out_valid) pulses++;
        end
        check("rst2.no_pulse", 32'(pulses), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle accumulator ALU in the SESO datapath. It registers its result and condition flags, generalises the operand width to `WIDTH`, and adds SUB, carry/negative flags and an optional multi-cycle shift-add multiplier. It sits between the accumulator/register-file read ports and the writeback/branch logic. The control unit issues one operation at a time through a valid/ready handshake.

## Interface
- `WIDTH`, default 8: operand and result width in bits, ≥ 2.
- `CLK` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept an operation.
- `op` in 4: opcode.
- `imm_sel` in 1: when 1, result = `imm`; `op` is ignored.
- `imm` in WIDTH: immediate operand.
- `acc` in WIDTH: accumulator operand; also the shift amount.
- `rb` in WIDTH: register operand.
- `out_valid` out 1: one-cycle pulse, result and flags updated.
- `result` out WIDTH: registered result, held between pulses.
- `flag_z`, `flag_n`, `flag_c` out 1 each: registered zero, negative and carry/borrow flags.
- `to_jump` out 1: registered branch condition, 1 after CMP-equal.

## Operation
- Opcodes:
  - 0 LSL = `rb << acc`
  - 1 LSR = `rb >> acc`
  - 2 ADD = `acc + rb`
  - 3 AND
  - 4 ORR
  - 5 EOR
  - 6 TAKE = `rb`
  - 7 MOVE = `acc`
  - 8 LDR = `rb`
  - 9 STR = `rb`
  - 10 CMP
  - 11 SUB = `acc - rb`
  - 12 MUL (macro-gated)
  - 13–15 undefined: result 0
- States:
  - IDLE → BUSY on an accepted MUL.
  - BUSY → IDLE after WIDTH iterations.
  - All other ops complete directly from IDLE.
- Handshake:
  - An op is accepted when `in_valid && in_ready`.
  - `in_ready = (state == IDLE)`; it is never asserted during BUSY.
  - Operands are sampled only on the accept edge and may change afterwards.
  - There is no output backpressure: `out_valid` is a pulse, and the consumer must capture it.
- Arithmetic: all results are truncated to WIDTH bits.
  - ADD: `C` = carry out.
  - SUB: `C` = borrow (`acc < rb` unsigned).
  - CMP: `result` = 1 if `acc == rb` else 0; `C` = borrow.
  - Shifts: if `acc >= WIDTH`, result 0 and `C` = 0. Otherwise `C` = last bit shifted out; shift by 0 gives `C` = 0.
  - Logic, move and immediate ops: `C` = 0.
- Flags on every completion:
  - `Z` = `(result == 0)`.
  - `N` = `result[WIDTH-1]`.
- `to_jump`:
  - Set to 1 on completion of a CMP with `acc == rb`.
  - Set to 0 on completion of any other op, including a CMP-unequal.
  - Held between completions.
- MUL:
  - Shift-add over WIDTH cycles.
  - `result` = low WIDTH bits of `acc * rb`.
  - `C` = 1 if the high half of the product is nonzero.
- Reset:
  - Return to IDLE.
  - `in_ready` = 1.
  - `out_valid`, `result`, all flags and `to_jump` = 0.
  - Any in-flight MUL is discarded with no completion pulse.

## Timing
- Single-cycle ops and immediate:
  - Accept at edge k.
  - `out_valid`, `result` and flags are valid after edge k; `out_valid` is high for the cycle following edge k.
  - Back-to-back accepts every cycle are permitted.
- MUL:
  - Accept at edge k, BUSY through edge k+WIDTH.
  - `out_valid` pulses after edge k+WIDTH; latency is WIDTH cycles.
  - `in_ready` drops after edge k and rises with `out_valid`.
  - A new op may be accepted in the `out_valid` cycle.
- `in_valid` while BUSY is ignored; the requester holds it until `in_ready`.
- Reset asserted during BUSY: the block is IDLE after that edge.
- Reset has priority over an accept on the same edge.

## Configuration
- `ALU_SEQ_MUL_EN` defined:
  - The BUSY state and the shift-add multiplier are compiled in.
  - Opcode 12 performs MUL as above.
- `ALU_SEQ_MUL_EN` undefined:
  - No BUSY state; `in_ready` is tied to 1 outside reset.
  - Opcode 12 is treated as undefined: single cycle, result 0, `Z` = 1, `C` = 0, `to_jump` = 0.

## Test plan
- Reset: after `reset` high for 2 cycles, `in_ready` = 1, `out_valid` = 0, `result` = 0x00, all flags and `to_jump` = 0.
- ADD `acc` = 0xF0, `rb` = 0x20: the next cycle shows `out_valid` pulse, `result` = 0x10, `C` = 1, `Z` = 0, `N` = 0. Then SUB 0x05 − 0x07 gives `result` = 0xFE, `C` = 1, `N` = 1, with back-to-back accepts.
- CMP 0x3C vs 0x3C gives `result` = 0x01, `to_jump` = 1, held through idle cycles. A following AND 0x0F & 0xF0 gives `result` = 0x00, `Z` = 1, `to_jump` = 0.
- Shifts:
  - LSL `rb` = 0x81, `acc` = 1 → 0x02, `C` = 1.
  - LSR `rb` = 0x81, `acc` = 8 → 0x00, `C` = 0, `Z` = 1.
  - Immediate `imm` = 0x80 → `result` = 0x80, `N` = 1.
- With `ALU_SEQ_MUL_EN`, MUL 0x12 × 0x11:
  - `in_ready` = 0 for 8 cycles, `out_valid` after 8 edges, `result` = 0x32, `C` = 1.
  - `in_valid` held during BUSY is accepted only when `in_ready` returns.
- With `ALU_SEQ_MUL_EN`, reset asserted mid-MUL: no `out_valid` pulse, all outputs 0, `in_ready` = 1 on the next cycle.
